count_sequencer: RTL

//  Run controller for the pulse-counter datapath: sequences an N-bit counter through

---
 rtl/count_sequencer_pkg.sv | 12 +
 rtl/count_sequencer_tick_gen.sv | 36 +++
 rtl/count_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count sequencer: run-state encoding as seen on the state output.
package count_sequencer_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// Prescaler for the count sequencer: one tick every DIV enabled cycles, cleared on clr.
module tick_gen #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned DIV_W = $clog2(DIV) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] Last = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run controller for the pulse counter: start/stop/pause sequencing, bounded up/down
// counting on a prescaled tick, one-shot or continuous.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DIV   = 4,
  parameter int unsigned DIV_W = $clog2(DIV) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         mode_cont,
  input  logic         dir_down,
  input  logic [N-1:0] limit,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         wrap,
  output logic [1:0]   state
);

  state_e       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] limit_q, limit_d;
  logic         cont_q, cont_d;
  logic         down_q, down_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         wrap_q, wrap_d;

  logic         active;
  logic         tick;
  logic [N-1:0] term_val;
  logic [N-1:0] first_val;

  // The edge that releases pause already counts, so a P-cycle pause delays the run by P.
  assign active = ((state_q == StRun) || (state_q == StPause)) && !pause;

  tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (active),
    .clr   (start | stop),
    .tick  (tick)
  );

  assign term_val  = down_q ? '0 : limit_q;
  assign first_val = down_q ? limit_q : '0;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    limit_d = limit_q;
    cont_d  = cont_q;
    down_d  = down_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else if (start) begin
      limit_d = limit;
      cont_d  = mode_cont;
      down_d  = dir_down;
      q_d     = dir_down ? limit : '0;
      state_d = StRun;
    end else begin
      case (state_q)
        StRun, StPause: begin
          if (pause) begin
            state_d = StPause;
          end else begin
            state_d = StRun;
            if (tick) begin
              if (q_q != term_val) begin
                q_d = down_q ? q_q - N'(1) : q_q + N'(1);
              end else if (cont_q) begin
                q_d    = first_val;
                wrap_d = 1'b1;
              end else begin
                done_d  = 1'b1;
                state_d = StIdle;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      limit_q <= '0;
      cont_q  <= 1'b0;
      down_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      limit_q <= limit_d;
      cont_q  <= cont_d;
      down_q  <= down_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q     = q_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule
